// File: rtl/fft_uart_pkg.sv
// Shared definitions for the FFT-to-UART capture path.
// Contents:
//   FFT_DW, FIFO_DW     sample and FIFO word widths
//   DRAIN_HOLD_DEFAULT  number of idle FIFO cycles that must be seen before the
//                       transmitter is switched off; derived from the UART baud
//                       constants so both sides stay consistent
//   fsm_state_e         frame packer state encoding
package fft_uart_pkg;

  localparam int FFT_DW  = 16;
  localparam int FIFO_DW = 32;

  localparam int CLK_HZ          = 100_000_000;
  localparam int UART_BAUD       = 115_200;
  localparam int UART_BIT_CYCLES = CLK_HZ / UART_BAUD;
  // One group is 6 bytes of 10 bits each (start + 8 data + stop).
  localparam int UART_GROUP_BITS = 6 * 10;
  // Rounded up to a power of two: 60 * 868 = 52080 -> 65536.
  localparam int DRAIN_HOLD_DEFAULT = 1 << $clog2(UART_GROUP_BITS * UART_BIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/fft_mag_l1.sv
// L1 magnitude of a complex sample: |a| + |b|.
// Ports:
//   a_i    signed FFT_DW-bit input
//   b_i    signed FFT_DW-bit input
//   mag_o  unsigned (FFT_DW+1)-bit sum; |-32768| = 32768, so the maximum is
//          65536 and the sum cannot overflow
module fft_mag_l1
  import fft_uart_pkg::*;
(
  input  logic signed [FFT_DW-1:0] a_i,
  input  logic signed [FFT_DW-1:0] b_i,
  output logic        [FFT_DW:0]   mag_o
);

  logic [FFT_DW:0] a_abs;
  logic [FFT_DW:0] b_abs;

  always_comb begin
    // Negate in one extra bit so the most negative input maps to +2^(FFT_DW-1).
    a_abs = a_i[FFT_DW-1] ? ((FFT_DW+1)'(0) - {a_i[FFT_DW-1], a_i}) : {1'b0, a_i};
    b_abs = b_i[FFT_DW-1] ? ((FFT_DW+1)'(0) - {b_i[FFT_DW-1], b_i}) : {1'b0, b_i};
    mag_o = a_abs + b_abs;
  end

endmodule

// File: rtl/fft_frame_packer.sv
// Captures one FFT frame of N_POINTS bins on a trigger, packs each bin into a
// 32-bit FIFO word and then keeps the UART enabled until the FIFO has stayed
// empty for DRAIN_HOLD consecutive cycles, so only whole frames are sent.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   trig                   capture request (pulse or level), honoured in IDLE only
//   fft_valid, fft_sop     FFT sample strobe / first-bin marker
//   fft_re, fft_im         signed sample parts
//   fifo_full, fifo_empty  FIFO status flags
//   fifo_wr_en, fifo_din   registered FIFO write port
//   uart_en                transmitter enable (high during DRAIN)
//   busy                   high whenever not IDLE
//   ovf_cnt                saturating count of samples dropped on a full FIFO
module fft_frame_packer
  import fft_uart_pkg::*;
#(
  parameter int N_POINTS   = 1024,
  parameter int MAG_MODE   = 0,
  parameter int DRAIN_HOLD = DRAIN_HOLD_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      trig,
  input  logic                      fft_valid,
  input  logic                      fft_sop,
  input  logic signed [FFT_DW-1:0]  fft_re,
  input  logic signed [FFT_DW-1:0]  fft_im,
  input  logic                      fifo_full,
  input  logic                      fifo_empty,
  output logic                      fifo_wr_en,
  output logic        [FIFO_DW-1:0] fifo_din,
  output logic                      uart_en,
  output logic                      busy,
  output logic        [7:0]         ovf_cnt
);

  // One spare bit so a count equal to 65535 can be compared after increment.
  localparam int                BIN_W     = 17;
  localparam int                HOLD_W    = $clog2(DRAIN_HOLD) + 1;
  localparam logic [BIN_W-1:0]  LAST_BIN  = BIN_W'(N_POINTS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DRAIN_HOLD - 1);

  fsm_state_e          state_q, state_d;
  logic [BIN_W-2:0]    bin_cnt_q, bin_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [7:0]          ovf_cnt_q, ovf_cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [FIFO_DW-1:0]  din_q, din_d;
  logic                uart_en_q;
  logic                busy_q;

  logic                take;
  logic [BIN_W-1:0]    bin_next;
  logic                last_bin;
  logic [FIFO_DW-1:0]  packed_word;

  generate
    if (MAG_MODE == 1) begin : g_mag
      logic [FFT_DW:0] mag;
      fft_mag_l1 u_mag (
        .a_i   (fft_re),
        .b_i   (fft_im),
        .mag_o (mag)
      );
      assign packed_word = {{(FIFO_DW - FFT_DW - 1){1'b0}}, mag};
    end else begin : g_raw
      assign packed_word = {fft_im, fft_re};
    end
  endgenerate

  assign bin_next = {1'b0, bin_cnt_q} + BIN_W'(1);
  assign last_bin = (bin_next == LAST_BIN);

  always_comb begin
    state_d    = state_q;
    bin_cnt_d  = bin_cnt_q;
    hold_cnt_d = hold_cnt_q;
    ovf_cnt_d  = ovf_cnt_q;
    wr_en_d    = 1'b0;
    din_d      = din_q;
    take       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d    = ST_ARM;
          ovf_cnt_d  = 8'd0;
          bin_cnt_d  = '0;
          hold_cnt_d = '0;
        end
      end
      // Only a start-of-frame sample opens the capture window.
      ST_ARM:     take = fft_valid & fft_sop;
      // Inside the window sop carries no meaning; every valid sample is a bin.
      ST_CAPTURE: take = fft_valid;
      ST_DRAIN: begin
        if (!fifo_empty) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take) begin
      bin_cnt_d = bin_next[BIN_W-2:0];
      // fifo_full is judged at the accepting edge only; a slot freeing in the
      // same cycle does not rescue the sample.
      if (!fifo_full) begin
        wr_en_d = 1'b1;
        din_d   = packed_word;
      end else if (ovf_cnt_q != 8'hFF) begin
        ovf_cnt_d = ovf_cnt_q + 8'd1;
      end
      if (last_bin) begin
        state_d    = ST_DRAIN;
        hold_cnt_d = '0;
      end else begin
        state_d = ST_CAPTURE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bin_cnt_q  <= '0;
      hold_cnt_q <= '0;
      ovf_cnt_q  <= 8'd0;
      wr_en_q    <= 1'b0;
      din_q      <= '0;
      uart_en_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_cnt_q  <= bin_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
      wr_en_q    <= wr_en_d;
      din_q      <= din_d;
      // Decoded from the next state so the flags line up with the state change.
      uart_en_q  <= (state_d == ST_DRAIN);
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign fifo_wr_en = wr_en_q;
  assign fifo_din   = din_q;
  assign uart_en    = uart_en_q;
  assign busy       = busy_q;
  assign ovf_cnt    = ovf_cnt_q;

endmodule

// File: tb/tb_fft_frame_packer.sv
// Randomised scoreboard bench for fft_frame_packer. Two instances (raw and
// magnitude packing) share one stimulus stream; each has its own queue of
// expected FIFO words filled by a frame-level reference model.
module tb_fft_frame_packer;

  localparam int N  = 8;
  localparam int DH = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               trig = 1'b0;
  logic               fft_valid = 1'b0;
  logic               fft_sop = 1'b0;
  logic signed [15:0] fft_re = '0;
  logic signed [15:0] fft_im = '0;
  logic               fifo_full = 1'b0;
  logic               fifo_empty = 1'b1;

  logic        wr_w   [2];
  logic [31:0] din_w  [2];
  logic        uart_w [2];
  logic        busy_w [2];
  logic [7:0]  ovf_w  [2];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] last0 = '0;
  logic [31:0] last1 = '0;
  logic [31:0] e0, e1;
  int          ovf_exp = 0;

  int s_re   [N];
  int s_im   [N];
  bit s_full [N];
  int s_gap  [N];

  fft_frame_packer #(.N_POINTS(N), .MAG_MODE(0), .DRAIN_HOLD(DH)) u_raw (
    .clk(clk), .rst_n(rst_n), .trig(trig), .fft_valid(fft_valid), .fft_sop(fft_sop),
    .fft_re(fft_re), .fft_im(fft_im), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_wr_en(wr_w[0]), .fifo_din(din_w[0]), .uart_en(uart_w[0]), .busy(busy_w[0]),
    .ovf_cnt(ovf_w[0])
  );

  fft_frame_packer #(.N_POINTS(N), .MAG_MODE(1), .DRAIN_HOLD(DH)) u_mag (
    .clk(clk), .rst_n(rst_n), .trig(trig), .fft_valid(fft_valid), .fft_sop(fft_sop),
    .fft_re(fft_re), .fft_im(fft_im), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_wr_en(wr_w[1]), .fifo_din(din_w[1]), .uart_en(uart_w[1]), .busy(busy_w[1]),
    .ovf_cnt(ovf_w[1])
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference packing straight from the word format definitions.
  function automatic logic [31:0] model_word(int mode, int re, int im);
    logic [31:0] w;
    int ar, ai;
    if (mode == 0) begin
      w[15:0]  = re[15:0];
      w[31:16] = im[15:0];
    end else begin
      ar = (re < 0) ? -re : re;
      ai = (im < 0) ? -im : im;
      w  = 32'(ar + ai);
    end
    return w;
  endfunction

  // Monitors: pop on every write, otherwise the word must hold its last value.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_w[0]) begin
        if (exp_q0.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL raw_unexpected_write: got 0x%08h, expected no write at %0t", din_w[0], $time);
        end else begin
          e0 = exp_q0.pop_front();
          check("raw_din", din_w[0], e0);
          last0 = e0;
          $display("raw write 0x%08h expected 0x%08h", din_w[0], e0);
        end
      end else begin
        check("raw_hold", din_w[0], last0);
      end
      if (wr_w[1]) begin
        if (exp_q1.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL mag_unexpected_write: got 0x%08h, expected no write at %0t", din_w[1], $time);
        end else begin
          e1 = exp_q1.pop_front();
          check("mag_din", din_w[1], e1);
          last1 = e1;
          $display("mag write 0x%08h expected 0x%08h", din_w[1], e1);
        end
      end else begin
        check("mag_hold", din_w[1], last1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(string tag, logic u, logic b);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_uart_en%0d", tag, d), uart_w[d], u);
      check($sformatf("%s_busy%0d", tag, d), busy_w[d], b);
    end
  endtask

  task automatic check_ovf(string tag, int v);
    for (int d = 0; d < 2; d++) check($sformatf("%s_ovf%0d", tag, d), ovf_w[d], v);
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) begin
      case ($urandom_range(0, 5))
        0:       s_re[k] = -32768;
        1:       s_re[k] = 32767;
        default: s_re[k] = int'($urandom_range(0, 65535)) - 32768;
      endcase
      case ($urandom_range(0, 5))
        0:       s_im[k] = -32768;
        1:       s_im[k] = 32767;
        default: s_im[k] = int'($urandom_range(0, 65535)) - 32768;
      endcase
      s_full[k] = ($urandom_range(0, 3) == 0);
      s_gap[k]  = $urandom_range(0, 2);
    end
  endtask

  task automatic reset_abort();
    #1;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("arst_wr%0d", d), wr_w[d], 0);
      check($sformatf("arst_din%0d", d), din_w[d], 0);
      check($sformatf("arst_uart%0d", d), uart_w[d], 0);
      check($sformatf("arst_busy%0d", d), busy_w[d], 0);
      check($sformatf("arst_ovf%0d", d), ovf_w[d], 0);
    end
    exp_q0.delete();
    exp_q1.delete();
    last0 = '0;
    last1 = '0;
    ovf_exp = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
  endtask

  // One frame: trigger, optional ignored samples while armed, then N bins.
  task automatic run_frame(int pre, int abort_at);
    fifo_empty = 1'b0;
    check_ovf("pre_trig", ovf_exp);
    trig = 1'b1;
    tick();
    ovf_exp = 0;
    check_ovf("trig_clear", 0);
    check_flags("arm", 1'b0, 1'b1);
    trig = 1'($urandom_range(0, 1));
    for (int j = 0; j < pre; j++) begin
      fft_valid = 1'($urandom_range(0, 1));
      fft_sop   = ~fft_valid;
      fft_re    = 16'($urandom);
      fft_im    = 16'($urandom);
      fifo_full = 1'($urandom_range(0, 1));
      tick();
      check_flags("arm_wait", 1'b0, 1'b1);
    end
    trig = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int g = 0; g < s_gap[k]; g++) begin
        fft_valid = 1'b0;
        fft_sop   = 1'($urandom_range(0, 1));
        fifo_full = 1'($urandom_range(0, 1));
        tick();
        check_flags("gap", 1'b0, 1'b1);
      end
      fft_valid = 1'b1;
      fft_sop   = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      fft_re    = 16'(s_re[k]);
      fft_im    = 16'(s_im[k]);
      fifo_full = s_full[k];
      if (s_full[k]) begin
        if (ovf_exp < 255) ovf_exp++;
      end else begin
        exp_q0.push_back(model_word(0, s_re[k], s_im[k]));
        exp_q1.push_back(model_word(1, s_re[k], s_im[k]));
      end
      tick();
      fft_valid = 1'b0;
      fft_sop   = 1'b0;
      fifo_full = 1'b0;
      if (k == abort_at) begin
        reset_abort();
        return;
      end
      check_flags("cap", (k == N - 1), 1'b1);
    end
    check_ovf("frame_end", ovf_exp);
  endtask

  // Drain: pre_low busy-FIFO cycles, optional run of g empties broken by one
  // non-empty cycle, then exactly DH empties must elapse before uart_en drops.
  task automatic drain(int pre_low, int g);
    trig = 1'b1;
    for (int j = 0; j < pre_low; j++) begin
      fifo_empty = 1'b0;
      tick();
      check_flags("drain_busy", 1'b1, 1'b1);
    end
    if (g > 0) begin
      for (int j = 0; j < g; j++) begin
        fifo_empty = 1'b1;
        tick();
        check_flags("drain_partial", 1'b1, 1'b1);
      end
      fifo_empty = 1'b0;
      tick();
      check_flags("drain_glitch", 1'b1, 1'b1);
    end
    trig = 1'b0;
    for (int k = 1; k <= DH; k++) begin
      fifo_empty = 1'b1;
      tick();
      check_flags("drain_hold", (k < DH), (k < DH));
    end
    repeat (2) begin
      tick();
      check_flags("idle_after", 1'b0, 1'b0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_wr%0d", d), wr_w[d], 0);
      check($sformatf("rst_din%0d", d), din_w[d], 0);
      check($sformatf("rst_uart%0d", d), uart_w[d], 0);
      check($sformatf("rst_busy%0d", d), busy_w[d], 0);
      check($sformatf("rst_ovf%0d", d), ovf_w[d], 0);
    end

    // Ramp frame: re = i, im = -i, no drops, drain broken at hold count 10.
    for (int k = 0; k < N; k++) begin
      s_re[k] = k; s_im[k] = -k; s_full[k] = 1'b0; s_gap[k] = 0;
    end
    run_frame(0, -1);
    drain(2, 10);

    // Magnitude corner cases plus three drops, including the final bin.
    fill_random();
    s_re[0] = -32768; s_im[0] = -32768;
    s_re[1] = 3;      s_im[1] = -4;
    for (int k = 0; k < N; k++) begin
      s_full[k] = (k == 3 || k == 5 || k == 7);
      s_gap[k]  = 0;
    end
    run_frame(3, -1);
    check_ovf("three_drops", 3);
    drain(0, 0);

    for (int f = 0; f < 6; f++) begin
      fill_random();
      run_frame($urandom_range(0, 3), -1);
      drain($urandom_range(0, 4), $urandom_range(0, 15));
    end

    // Reset in the middle of a capture; afterwards sop alone must not start a frame.
    fill_random();
    run_frame(1, 3);
    for (int j = 0; j < 4; j++) begin
      fft_valid = 1'b1;
      fft_sop   = 1'b1;
      fft_re    = 16'($urandom);
      fft_im    = 16'($urandom);
      tick();
      check_flags("post_rst", 1'b0, 1'b0);
    end
    fft_valid = 1'b0;
    fft_sop   = 1'b0;

    fill_random();
    run_frame(0, -1);
    drain(1, 0);

    tick();
    check("raw_leftover", exp_q0.size(), 0);
    check("mag_leftover", exp_q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_packer.md
# fft_frame_packer

Capture stage between the FFT core output and the transmit FIFO. On a trigger it captures exactly one FFT frame of `N_POINTS` bins, packs each bin into a 32-bit word, and writes it into the FIFO. It then enables the UART transmitter until the FIFO has drained, so the transmitter serialises complete frames only.

## Interface
- `N_POINTS`, 1024: bins captured per frame; range 2..65535.
- `MAG_MODE`, 0: 0 = pack raw `{im, re}`; 1 = pack L1 magnitude `|re|+|im|`, zero-extended.
- `DRAIN_HOLD`, 65536: consecutive `fifo_empty` cycles required before `uart_en` drops. This covers one full 6-byte UART word group at 115200 baud and 100 MHz.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `trig`  in  1  capture request; single-cycle pulse or level.
- `fft_valid`  in  1  FFT output sample valid.
- `fft_sop`  in  1  qualifies the first bin of an FFT frame; meaningful only with `fft_valid`.
- `fft_re`  in  16  real part, signed two's complement.
- `fft_im`  in  16  imaginary part, signed two's complement.
- `fifo_full`  in  1  FIFO full flag, write side.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_wr_en`  out  1  FIFO write strobe, one cycle per word.
- `fifo_din`  out  32  FIFO write data.
- `uart_en`  out  1  transmitter enable.
- `busy`  out  1  high in any state other than IDLE.
- `ovf_cnt`  out  8  samples dropped because the FIFO was full; saturates at 255 and is cleared on each new `trig` accept.

## Operation
- FSM states are IDLE, ARM, CAPTURE, DRAIN.
- IDLE: on `trig`=1, go to ARM, clear `ovf_cnt`, clear the bin counter.
- ARM: ignore samples until `fft_valid & fft_sop`. That sample is bin 0 and is processed as in CAPTURE; the next state is CAPTURE, or DRAIN if `N_POINTS` is reached.
- CAPTURE: each `fft_valid` sample increments the bin counter.
  - If `fifo_full`=0, write the packed word.
  - If `fifo_full`=1, drop the word and increment `ovf_cnt`, saturating.
  - `fft_sop` is treated as an ordinary sample here; it does not restart the frame.
  - When the counter reaches `N_POINTS`, go to DRAIN.
- DRAIN: `uart_en`=1.
  - The hold counter clears whenever `fifo_empty`=0 and increments while `fifo_empty`=1.
  - When it reaches `DRAIN_HOLD`-1 with `fifo_empty`=1, go to IDLE.
- `trig` is ignored outside IDLE; a held level retriggers only after IDLE is reached.
- Packing:
  - MAG_MODE=0: `fifo_din` = `{fft_im, fft_re}`, with re in bits 15:0.
  - MAG_MODE=1: `fifo_din` = `{15'b0, |re|+|im|}`, a 17-bit unsigned sum. |−32768| = 32768, so the maximum is 65536 and no overflow is possible.
- Reset, at any time including mid-frame: FSM goes to IDLE and all counters clear. No partial-frame recovery.

## Timing
- Reset values: `fifo_wr_en`=0, `fifo_din`=0, `uart_en`=0, `busy`=0, `ovf_cnt`=0.
- Outputs are registered.
- A sample accepted at edge t produces `fifo_wr_en`/`fifo_din` valid in cycle t+1. `fifo_din` holds its last value when `fifo_wr_en`=0.
- `fifo_full` is sampled in the same cycle as `fft_valid`. A full FIFO at that edge means the sample is dropped, even if the FIFO frees in the same cycle.
- The N-th sample accepted at t gives its write in cycle t+1 and DRAIN entry at t+1. `uart_en`=1 from t+1 and is held continuously until the DRAIN exit; it drops to 0 the cycle after the hold condition completes.
- `busy` goes high the cycle after `trig` is accepted and goes low with `uart_en`.
- Back-to-back `fft_valid` samples are accepted at full rate, one per cycle; there is no backpressure to the FFT.

## Structure
- Shared package `fft_uart_pkg` holds:
  - the FSM state enum;
  - `FFT_DW`=16 and `FIFO_DW`=32 constants;
  - the default `DRAIN_HOLD` value, so it stays consistent with the transmitter baud constant.
- One combinational sub-module, `fft_mag_l1`: takes two signed 16-bit values and returns the 17-bit |a|+|b|. Instantiate it only when MAG_MODE=1.

## Test plan
- N_POINTS=8, MAG_MODE=0, `trig`, then 8 consecutive samples starting with sop, re=i, im=−i: 8 writes, word0=0x00000000, word1=0xFFFF0001; `uart_en` rises the cycle of the 8th write.
- Samples without sop after `trig`: no writes, FSM stays in ARM, `busy`=1; the first sop sample starts the capture.
- MAG_MODE=1, re=−32768, im=−32768: `fifo_din`=0x00010000. re=3, im=−4: 0x00000007.
- `fifo_full`=1 for 3 of 8 samples: 5 writes, `ovf_cnt`=3, DRAIN still entered after the 8th sample. Next `trig` clears `ovf_cnt` to 0.
- DRAIN with DRAIN_HOLD=16: `fifo_empty` toggles low at hold count 10, restarting the count. `uart_en` falls only after 16 consecutive empty cycles; `trig` during DRAIN is ignored.
- `rst_n` asserted mid-CAPTURE: all outputs are 0 immediately, asynchronously. After release the FSM is in IDLE and needs a new `trig`.
